// File: rtl/t02_keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : t02_keypad_pkg
//  Description : Shared definitions for the keypad emulator. Holds the FSM
//                state encoding, the special key values ('*', '#') and the
//                column/row one-hot codes. The scanner's decode table uses
//                the same codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package t02_keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] KEY_STAR = 8'h2A;
   localparam logic [7:0] KEY_HASH = 8'h23;

   localparam logic [3:0] COL_0 = 4'b0001;
   localparam logic [3:0] COL_1 = 4'b0010;
   localparam logic [3:0] COL_2 = 4'b0100;
   localparam logic [3:0] COL_3 = 4'b1000;

   localparam logic [3:0] ROW_0 = 4'b0001;
   localparam logic [3:0] ROW_1 = 4'b0010;
   localparam logic [3:0] ROW_2 = 4'b0100;
   localparam logic [3:0] ROW_3 = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/t02_key_encode.sv
`default_nettype none
// ============================================================================
//  Module      : t02_key_encode
//  Description : Combinational map from a key value to the column/row
//                one-hot pair that a physical press of that key would short.
//  Ports       : key_i   - key value (8 bit)
//                col_o   - column one-hot the key sits on
//                row_o   - row one-hot the key sits on
//                valid_o - high when key_i is one of the 16 mapped keys
//  Revision    : 1.0 - initial release
// ============================================================================
module t02_key_encode
   import t02_keypad_pkg::*;
(
   input  logic [7:0] key_i,
   output logic [3:0] col_o,
   output logic [3:0] row_o,
   output logic       valid_o
);

   always_comb begin
      col_o   = 4'b0000;
      row_o   = 4'b0000;
      valid_o = 1'b1;
      case (key_i)
         8'h01:    begin col_o = COL_0; row_o = ROW_0; end
         8'h02:    begin col_o = COL_0; row_o = ROW_1; end
         8'h03:    begin col_o = COL_0; row_o = ROW_2; end
         8'h0A:    begin col_o = COL_0; row_o = ROW_3; end
         8'h04:    begin col_o = COL_1; row_o = ROW_0; end
         8'h05:    begin col_o = COL_1; row_o = ROW_1; end
         8'h06:    begin col_o = COL_1; row_o = ROW_2; end
         8'h0B:    begin col_o = COL_1; row_o = ROW_3; end
         8'h07:    begin col_o = COL_2; row_o = ROW_0; end
         8'h08:    begin col_o = COL_2; row_o = ROW_1; end
         8'h09:    begin col_o = COL_2; row_o = ROW_2; end
         8'h0C:    begin col_o = COL_2; row_o = ROW_3; end
         KEY_STAR: begin col_o = COL_3; row_o = ROW_0; end
         8'h00:    begin col_o = COL_3; row_o = ROW_1; end
         KEY_HASH: begin col_o = COL_3; row_o = ROW_2; end
         8'h0D:    begin col_o = COL_3; row_o = ROW_3; end
         default:  valid_o = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/t02_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : t02_keypad_emulator
//  Description : Emulates a physical key press on the row side of a 4x4
//                scanned keypad. A key accepted in IDLE is held pressed for
//                HOLD_CYCLES, then forcibly released for GAP_CYCLES before
//                the next key is accepted.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                key_data   - key value to press
//                key_valid  - key_data valid (held until key_ready)
//                key_ready  - emulator idle and able to accept a key
//                scan_col   - one-hot column driven by the scanner
//                read_row   - one-hot row returned to the scanner
//                pressing   - high while the key is held
//                done       - pulse on the final gap cycle
//                err        - pulse when an unmapped key is offered
//  Revision    : 1.0 - initial release
// ============================================================================
module t02_keypad_emulator
   import t02_keypad_pkg::*;
#(
   parameter int HOLD_CYCLES = 64,
   parameter int GAP_CYCLES  = 32,
   parameter int CNT_W       = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_data,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [3:0] scan_col,
   output logic [3:0] read_row,
   output logic       pressing,
   output logic       done,
   output logic       err
);

   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   // With a one-cycle gap the first gap cycle is also the last one.
   localparam logic             GAP_IS_ONE = (GAP_CYCLES == 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       col_q;
   logic [3:0]       row_q;
   logic             key_ready_q;
   logic             pressing_q;
   logic             done_q;

   logic [3:0]       enc_col;
   logic [3:0]       enc_row;
   logic             enc_valid;
   logic             accept;

   t02_key_encode u_encode (
      .key_i   (key_data),
      .col_o   (enc_col),
      .row_o   (enc_row),
      .valid_o (enc_valid)
   );

   assign accept = key_valid && key_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         col_q       <= 4'b0000;
         row_q       <= 4'b0000;
         key_ready_q <= 1'b0;
         pressing_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               key_ready_q <= 1'b1;
               if (accept && enc_valid) begin
                  col_q       <= enc_col;
                  row_q       <= enc_row;
                  cnt_q       <= HOLD_LOAD;
                  state_q     <= ST_PRESS;
                  key_ready_q <= 1'b0;
                  pressing_q  <= 1'b1;
               end
            end
            ST_PRESS: begin
               if (cnt_q == '0) begin
                  cnt_q      <= GAP_LOAD;
                  state_q    <= ST_GAP;
                  pressing_q <= 1'b0;
                  done_q     <= GAP_IS_ONE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_GAP: begin
               if (cnt_q == '0) begin
                  state_q     <= ST_IDLE;
                  key_ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
                  // Raise done so it lines up with the cycle where cnt_q is 0.
                  if (cnt_q == CNT_ONE) begin
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               key_ready_q <= 1'b0;
               pressing_q  <= 1'b0;
            end
         endcase
      end
   end

   // Combinational so the scanner sees the row on the same edge it samples.
   assign read_row  = ((state_q == ST_PRESS) && (scan_col == col_q)) ? row_q : 4'b0000;
   assign key_ready = key_ready_q;
   assign pressing  = pressing_q;
   assign done      = done_q;
   assign err       = accept && !enc_valid;

endmodule
`default_nettype wire

// File: tb/tb_t02_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t02_keypad_emulator
//  Description : Self-checking bench for t02_keypad_emulator. Expected done/
//                err events are queued when a key is offered; a monitor pops
//                them when the DUT raises done or err. A small scanner model
//                decodes read_row back into a key value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t02_keypad_emulator;

   localparam int HOLD = 64;
   localparam int GAP  = 32;

   typedef struct packed {
      logic       is_err;
      logic [7:0] val;
   } ev_t;

   logic       clk;
   logic       rst;
   logic [7:0] key_data;
   logic       key_valid;
   logic       key_ready;
   logic [3:0] scan_col;
   logic [3:0] read_row;
   logic       pressing;
   logic       done;
   logic       err;

   int         n_checks = 0;
   int         n_fail   = 0;
   ev_t        sb[$];
   logic [7:0] scanned  = 8'hFF;
   logic [3:0] scan_pat [4];
   int         pidx     = 0;

   t02_keypad_emulator #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .CNT_W       (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_data  (key_data),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .scan_col  (scan_col),
      .read_row  (read_row),
      .pressing  (pressing),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scanner-side decode of (column, row) back to the key value.
   function automatic logic [7:0] decode(input logic [3:0] c, input logic [3:0] r);
      case ({c, r})
         8'h11: return 8'h01;  8'h12: return 8'h02;  8'h14: return 8'h03;  8'h18: return 8'h0A;
         8'h21: return 8'h04;  8'h22: return 8'h05;  8'h24: return 8'h06;  8'h28: return 8'h0B;
         8'h41: return 8'h07;  8'h42: return 8'h08;  8'h44: return 8'h09;  8'h48: return 8'h0C;
         8'h81: return 8'h2A;  8'h82: return 8'h00;  8'h84: return 8'h23;  8'h88: return 8'h0D;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      pidx     = (pidx + 1) % 4;
      scan_col = scan_pat[pidx];
   endtask

   // Offer key k, check the full press/gap window. side_key/side_valid are
   // driven during PRESS (must be ignored); chain keeps key_valid high
   // through GAP so the next key is taken on the first idle cycle.
   task automatic run_press(input logic [7:0] k, input logic [3:0] ecol, input logic [3:0] erow,
                            input logic [7:0] side_key, input logic side_valid, input logic chain);
      logic got;
      key_data  = k;
      key_valid = 1'b1;
      got       = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (key_ready) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL accept_timeout: key %h not accepted, key_ready=%b expected 1", k, key_ready);
         key_valid = 1'b0;
         return;
      end
      sb.push_back('{1'b0, k});
      tick();
      key_data  = side_key;
      key_valid = side_valid;
      for (int n = 1; n <= HOLD; n++) begin
         @(negedge clk);
         chk("press_pressing", {7'd0, pressing}, 8'd1);
         chk("press_ready", {7'd0, key_ready}, 8'd0);
         chk("press_row", {4'd0, read_row}, {4'd0, (scan_col == ecol) ? erow : 4'b0000});
         tick();
      end
      key_valid = chain;
      for (int n = 1; n <= GAP; n++) begin
         @(negedge clk);
         chk("gap_row", {4'd0, read_row}, 8'd0);
         chk("gap_pressing", {7'd0, pressing}, 8'd0);
         chk("gap_ready", {7'd0, key_ready}, 8'd0);
         chk("gap_done", {7'd0, done}, {7'd0, (n == GAP)});
         tick();
      end
      if (!chain) begin
         @(negedge clk);
         chk("idle_ready", {7'd0, key_ready}, 8'd1);
         chk("idle_done", {7'd0, done}, 8'd0);
         tick();
      end
   endtask

   // Monitor: pops the scoreboard whenever done or err is presented.
   always @(negedge clk) begin
      ev_t        e;
      logic [7:0] act;
      if (!rst) begin
         if (read_row != 4'b0000) scanned = decode(scan_col, read_row);
         if (done || err) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: done=%b err=%b, expected no event", done, err);
            end else begin
               e   = sb.pop_front();
               act = err ? key_data : scanned;
               if (e.is_err !== err || e.val !== act) begin
                  n_fail++;
                  $display("FAIL sb_event: got err=%b key=%h, expected err=%b key=%h",
                           err, act, e.is_err, e.val);
               end
            end
         end
         if (key_valid && key_ready) scanned = 8'hFF;
      end
   end

   initial begin
      scan_pat  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      scan_col  = scan_pat[0];
      rst       = 1'b1;
      key_data  = 8'h00;
      key_valid = 1'b0;

      // Reset
      tick();
      tick();
      @(negedge clk);
      chk("rst_ready", {7'd0, key_ready}, 8'd0);
      chk("rst_row", {4'd0, read_row}, 8'd0);
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("post_rst_ready", {7'd0, key_ready}, 8'd1);
      chk("post_rst_row", {4'd0, read_row}, 8'd0);
      chk("post_rst_pressing", {7'd0, pressing}, 8'd0);
      chk("post_rst_done", {7'd0, done}, 8'd0);
      chk("post_rst_err", {7'd0, err}, 8'd0);
      tick();

      // Key 5 with rotating scan columns
      run_press(8'h05, 4'b0010, 4'b0010, 8'h00, 1'b0, 1'b0);

      // '*' then '#', back to back: '#' held valid throughout
      run_press(8'h2A, 4'b1000, 4'b0001, 8'h23, 1'b1, 1'b1);
      run_press(8'h23, 4'b1000, 4'b0100, 8'h00, 1'b0, 1'b0);

      // Unmapped key
      key_data  = 8'h47;
      key_valid = 1'b1;
      sb.push_back('{1'b1, 8'h47});
      @(negedge clk);
      chk("err_pulse", {7'd0, err}, 8'd1);
      chk("err_ready", {7'd0, key_ready}, 8'd1);
      tick();
      key_valid = 1'b0;
      @(negedge clk);
      chk("err_clear", {7'd0, err}, 8'd0);
      chk("err_stay_ready", {7'd0, key_ready}, 8'd1);
      chk("err_row", {4'd0, read_row}, 8'd0);
      chk("err_pressing", {7'd0, pressing}, 8'd0);
      tick();

      // Reset in the 10th PRESS cycle of key D
      key_data  = 8'h0D;
      key_valid = 1'b1;
      @(negedge clk);
      chk("rstp_ready", {7'd0, key_ready}, 8'd1);
      tick();
      key_valid = 1'b0;
      repeat (9) tick();
      @(negedge clk);
      chk("rstp_pressing", {7'd0, pressing}, 8'd1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("rstp_row", {4'd0, read_row}, 8'd0);
      chk("rstp_pressing_off", {7'd0, pressing}, 8'd0);
      chk("rstp_done", {7'd0, done}, 8'd0);
      rst = 1'b0;
      tick();
      run_press(8'h0B, 4'b0010, 4'b1000, 8'h00, 1'b0, 1'b0);

      // Key 1 with illegal scan columns and an ignored key during PRESS
      scan_pat = '{4'b0011, 4'b0000, 4'b0001, 4'b0010};
      run_press(8'h01, 4'b0001, 4'b0001, 8'h02, 1'b1, 1'b0);
      scan_pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

      repeat (3) tick();
      chk("sb_empty", 8'(sb.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
